// File: rtl/hdc_stream_adapter.sv
// Host-side adapter: deserialises host words into one feature sample for the
// accelerator (double buffered) and returns tagged valence/arousal results.
module hdc_stream_adapter #(
  parameter int NUM_CHANNEL   = 214,
  parameter int CHANNEL_WIDTH = 2,
  parameter int IN_WIDTH      = 32,
  parameter int TAG_WIDTH     = 8,
  localparam int SAMPLE_BITS  = 3 * NUM_CHANNEL * CHANNEL_WIDTH,
  localparam int NUM_WORDS    = (SAMPLE_BITS + IN_WIDTH - 1) / IN_WIDTH,
  localparam int WC_W         = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [IN_WIDTH-1:0]    s_data,
  input  logic                   flush,
  output logic                   fin_valid,
  input  logic                   fin_ready,
  output logic [SAMPLE_BITS-1:0] features_top,
  input  logic                   dout_valid,
  output logic                   dout_ready,
  input  logic                   valence,
  input  logic                   arousal,
  output logic                   r_valid,
  input  logic                   r_ready,
  output logic [1:0]             r_data,
  output logic [TAG_WIDTH-1:0]   r_tag,
  output logic [15:0]            samples_sent
);

  // Handshake rule for every stream here: a transfer happens on a rising clk
  // edge where valid and ready are both 1; a producer holds valid and its
  // payload stable until that edge, and ready never depends on that valid.

  logic                   live_q;
  logic [WC_W-1:0]        wc_q, wc_d;
  logic                   asm_full_q, asm_full_d;
  logic [SAMPLE_BITS-1:0] asm_w;
  logic                   fin_valid_q, fin_valid_d;
  logic [SAMPLE_BITS-1:0] features_q, features_d;
  logic [15:0]            sent_q, sent_d;
  logic                   r_valid_q, r_valid_d;
  logic [1:0]             r_data_q, r_data_d;
  logic [TAG_WIDTH-1:0]   r_tag_q, r_tag_d;
  logic [TAG_WIDTH-1:0]   tag_cnt_q, tag_cnt_d;

  logic accept_word;
  logic last_word;
  logic xfer;
  logic fin_hs;
  logic cap;
  logic r_hs;

  // live_q holds both ready outputs low while reset is asserted and lets them
  // rise on the first edge after release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) live_q <= 1'b0;
    else      live_q <= 1'b1;
  end

  assign s_ready    = live_q && !asm_full_q;
  assign dout_ready = live_q && (!r_valid_q || r_ready);

  assign accept_word = s_valid && s_ready && !flush;
  assign last_word   = (wc_q == WC_W'(NUM_WORDS - 1));
  assign xfer        = asm_full_q && (!fin_valid_q || fin_ready);
  assign fin_hs      = fin_valid_q && fin_ready;
  assign cap         = dout_valid && dout_ready;
  assign r_hs        = r_valid_q && r_ready;

  // One register slice per word; the final slice keeps only the bits that
  // fall inside the sample, so the high bits of the last word are dropped.
  for (genvar w = 0; w < NUM_WORDS; w++) begin : g_word
    localparam int LO = w * IN_WIDTH;
    localparam int WW = (SAMPLE_BITS - LO < IN_WIDTH) ? (SAMPLE_BITS - LO) : IN_WIDTH;
    logic [WW-1:0] word_q;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst)                                       word_q <= '0;
      else if (accept_word && (wc_q == WC_W'(w)))     word_q <= s_data[WW-1:0];
    end

    assign asm_w[LO +: WW] = word_q;
  end

  always_comb begin
    wc_d       = wc_q;
    asm_full_d = asm_full_q;
    if (flush) begin
      wc_d       = '0;
      asm_full_d = 1'b0;
    end else if (accept_word) begin
      wc_d       = last_word ? '0 : wc_q + 1'b1;
      asm_full_d = last_word;
    end else if (xfer) begin
      asm_full_d = 1'b0;
    end
  end

  // Output stage: a loaded sample stays put until the accelerator takes it;
  // a waiting sample moves in on that same edge so fin_valid never drops.
  always_comb begin
    fin_valid_d = fin_valid_q;
    features_d  = features_q;
    sent_d      = sent_q;
    if (xfer) begin
      fin_valid_d = 1'b1;
      features_d  = asm_w;
    end else if (fin_hs) begin
      fin_valid_d = 1'b0;
    end
    if (fin_hs) sent_d = sent_q + 16'd1;
  end

  always_comb begin
    r_valid_d = r_valid_q;
    r_data_d  = r_data_q;
    r_tag_d   = r_tag_q;
    tag_cnt_d = tag_cnt_q;
    if (cap) begin
      r_valid_d = 1'b1;
      r_data_d  = {valence, arousal};
      r_tag_d   = tag_cnt_q;
      tag_cnt_d = tag_cnt_q + 1'b1;
    end else if (r_hs) begin
      r_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wc_q        <= '0;
      asm_full_q  <= 1'b0;
      fin_valid_q <= 1'b0;
      features_q  <= '0;
      sent_q      <= '0;
      r_valid_q   <= 1'b0;
      r_data_q    <= '0;
      r_tag_q     <= '0;
      tag_cnt_q   <= '0;
    end else begin
      wc_q        <= wc_d;
      asm_full_q  <= asm_full_d;
      fin_valid_q <= fin_valid_d;
      features_q  <= features_d;
      sent_q      <= sent_d;
      r_valid_q   <= r_valid_d;
      r_data_q    <= r_data_d;
      r_tag_q     <= r_tag_d;
      tag_cnt_q   <= tag_cnt_d;
    end
  end

  assign fin_valid    = fin_valid_q;
  assign features_top = features_q;
  assign samples_sent = sent_q;
  assign r_valid      = r_valid_q;
  assign r_data       = r_data_q;
  assign r_tag        = r_tag_q;

endmodule
